stream_upsize_buf: RTL and testbench

STREAM_UPSIZE_BUF -- requirements
Module: stream_upsize_buf

---
 rtl/stream_upsize_buf_if.sv | 29 ++
 rtl/stream_upsize_buf.sv | 88 ++++++++
 tb/tb_stream_upsize_buf.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_upsize_buf_if.sv
// Stream bundle for the upsizer: narrow beat side in, wide lane-array side out.
// Latency: none (wiring only).
// Backpressure: carries s_ready_o / m_ready_i handshakes unchanged.
interface stream_upsize_buf_if #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DATA_RATIO = 4
);
    logic [T_DATA_WIDTH-1:0] s_data_i;
    logic                    s_last_i;
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] m_keep_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    // Seen from the upsizer itself.
    modport slave (
        input  s_data_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
    );

    // Seen from the environment that feeds beats and drains words.
    modport master (
        output s_data_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
    );
endinterface

// File: rtl/stream_upsize_buf.sv
// Packs T_DATA_RATIO narrow beats into one wide word with per-lane keep; s_last_i closes a partial word.
// Latency: one clock from acceptance of the closing beat to m_valid_o.
// Backpressure: s_ready_o = !m_valid_o || m_ready_i; a held word stalls input, back-to-back words without bubbles.
module stream_upsize_buf #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DATA_RATIO = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    stream_upsize_buf_if.slave    bus
);
    localparam int CNT_W = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(T_DATA_RATIO - 1);

    logic [CNT_W-1:0]        cnt;
    logic [T_DATA_WIDTH-1:0] acc_data [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] acc_keep;

    logic [T_DATA_WIDTH-1:0] m_data_q [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] m_keep_q;
    logic                    m_last_q;
    logic                    m_valid_q;

    logic s_ready;
    logic in_fire;
    logic out_fire;
    logic close_word;

    // The output register can take a new word whenever it is empty or being drained this cycle.
    assign s_ready    = !m_valid_q || bus.m_ready_i;
    assign in_fire    = bus.s_valid_i && s_ready;
    assign out_fire   = m_valid_q && bus.m_ready_i;
    assign close_word = in_fire && ((cnt == CNT_MAX) || bus.s_last_i);

    assign bus.s_ready_o = s_ready;
    assign bus.m_data_o  = m_data_q;
    assign bus.m_keep_o  = m_keep_q;
    assign bus.m_last_o  = m_last_q;
    assign bus.m_valid_o = m_valid_q;

    // Accumulate beats into lanes; on the closing beat move accumulator plus that beat into the output register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt       <= '0;
            acc_keep  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                m_data_q[i] <= '0;
            end
        end else begin
            if (close_word) begin
                // Lanes never written in this word are forced to zero so stale accumulator data cannot leak.
                for (int i = 0; i < T_DATA_RATIO; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        m_data_q[i] <= bus.s_data_i;
                        m_keep_q[i] <= 1'b1;
                    end else if (acc_keep[i]) begin
                        m_data_q[i] <= acc_data[i];
                        m_keep_q[i] <= 1'b1;
                    end else begin
                        m_data_q[i] <= '0;
                        m_keep_q[i] <= 1'b0;
                    end
                end
                m_last_q <= bus.s_last_i;
                cnt      <= '0;
                acc_keep <= '0;
            end else if (in_fire) begin
                for (int i = 0; i < T_DATA_RATIO; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        acc_data[i] <= bus.s_data_i;
                        acc_keep[i] <= 1'b1;
                    end
                end
                cnt <= cnt + 1'b1;
            end

            // A new word overrides the drain so consecutive words flow without a bubble.
            if (close_word) begin
                m_valid_q <= 1'b1;
            end else if (out_fire) begin
                m_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_upsize_buf.sv
// Self-checking bench for stream_upsize_buf (8-bit beats, ratio 4).
// Latency: checks one-clock closing-beat-to-valid timing.
// Backpressure: exercises stalls, back-to-back drains and random ready.
module tb_stream_upsize_buf;
    localparam int W = 8;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stream_upsize_buf_if #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) bus ();

    stream_upsize_buf #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic        rst_n;
        logic        sv;
        logic [7:0]  sd;
        logic        sl;
        logic        mr;
        logic        mv;
        logic [3:0]  keep;
        logic        last;
        logic [31:0] data;
        logic        srdy;
        logic        chk_all;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    function automatic vec_t mk(logic r, logic sv, logic [7:0] sd, logic sl, logic mr,
                                logic mv, logic [3:0] keep, logic last, logic [31:0] data,
                                logic srdy, logic chk_all);
        vec_t v;
        v.rst_n = r; v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
        v.mv = mv; v.keep = keep; v.last = last; v.data = data;
        v.srdy = srdy; v.chk_all = chk_all;
        return v;
    endfunction

    function automatic logic [31:0] dut_data();
        logic [31:0] d;
        d = '0;
        for (int l = 0; l < R; l++) d[8*l +: 8] = bus.m_data_o[l];
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [7:0] sd, input logic sl, input logic mr);
        bus.s_valid_i = sv;
        bus.s_data_i  = sd;
        bus.s_last_i  = sl;
        bus.m_ready_i = mr;
    endtask

    vec_t        vecs [19];
    word_t       exp_q [$];
    logic [7:0]  part [$];

    initial begin
        // Cycle-by-cycle vectors: inputs for the edge, expected outputs right after it.
        vecs[0]  = mk(1, 1, 8'h11, 0, 1,  0, 4'h0, 0, 32'h0,        1, 0);
        vecs[1]  = mk(1, 1, 8'h22, 0, 1,  0, 4'h0, 0, 32'h0,        1, 0);
        vecs[2]  = mk(1, 1, 8'h33, 0, 1,  0, 4'h0, 0, 32'h0,        1, 0);
        vecs[3]  = mk(1, 1, 8'h44, 1, 1,  1, 4'hF, 1, 32'h44332211, 1, 0);
        vecs[4]  = mk(1, 0, 8'h00, 0, 1,  0, 4'h0, 0, 32'h0,        1, 0);
        vecs[5]  = mk(1, 1, 8'hA1, 0, 1,  0, 4'h0, 0, 32'h0,        1, 0);
        vecs[6]  = mk(1, 1, 8'hA2, 1, 1,  1, 4'h3, 1, 32'h0000A2A1, 1, 0);
        vecs[7]  = mk(1, 0, 8'h00, 0, 1,  0, 4'h0, 0, 32'h0,        1, 0);
        vecs[8]  = mk(1, 1, 8'h5A, 1, 1,  1, 4'h1, 1, 32'h0000005A, 1, 0);
        vecs[9]  = mk(1, 0, 8'h00, 0, 0,  1, 4'h1, 1, 32'h0000005A, 0, 0);
        vecs[10] = mk(1, 0, 8'h00, 0, 1,  0, 4'h0, 0, 32'h0,        1, 0);
        vecs[11] = mk(1, 1, 8'hEE, 0, 1,  0, 4'h0, 0, 32'h0,        1, 0);
        vecs[12] = mk(1, 1, 8'hEF, 0, 1,  0, 4'h0, 0, 32'h0,        1, 0);
        vecs[13] = mk(0, 1, 8'h99, 1, 1,  0, 4'h0, 0, 32'h0,        1, 1);
        vecs[14] = mk(1, 1, 8'h01, 0, 1,  0, 4'h0, 0, 32'h0,        1, 0);
        vecs[15] = mk(1, 1, 8'h02, 0, 1,  0, 4'h0, 0, 32'h0,        1, 0);
        vecs[16] = mk(1, 1, 8'h03, 0, 1,  0, 4'h0, 0, 32'h0,        1, 0);
        vecs[17] = mk(1, 1, 8'h04, 0, 1,  1, 4'hF, 0, 32'h04030201, 1, 0);
        vecs[18] = mk(1, 0, 8'h00, 0, 1,  0, 4'h0, 0, 32'h0,        1, 0);

        // Reset state.
        drive(1, 8'h77, 1, 1);
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_s_ready", 32'(bus.s_ready_o), 32'd1);
        chk("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
        chk("rst_m_keep",  32'(bus.m_keep_o),  32'd0);
        chk("rst_m_last",  32'(bus.m_last_o),  32'd0);
        chk("rst_m_data",  dut_data(),         32'd0);
        drive(0, 8'h00, 0, 1);
        rst_n = 1'b1;
        tick();

        // Table-driven directed vectors.
        for (int v = 0; v < 19; v++) begin
            rst_n = vecs[v].rst_n;
            drive(vecs[v].sv, vecs[v].sd, vecs[v].sl, vecs[v].mr);
            tick();
            chk($sformatf("vec%0d_m_valid", v), 32'(bus.m_valid_o), 32'(vecs[v].mv));
            chk($sformatf("vec%0d_s_ready", v), 32'(bus.s_ready_o), 32'(vecs[v].srdy));
            if (vecs[v].mv || vecs[v].chk_all) begin
                chk($sformatf("vec%0d_m_keep", v), 32'(bus.m_keep_o), 32'(vecs[v].keep));
                chk($sformatf("vec%0d_m_last", v), 32'(bus.m_last_o), 32'(vecs[v].last));
                chk($sformatf("vec%0d_m_data", v), dut_data(), vecs[v].data);
            end
        end
        rst_n = 1'b1;

        // Backpressure: first word held while downstream stalls, then both words drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'(8'h10 + i), 0, 0);
            #1;
            chk("bp_s_ready_fill", 32'(bus.s_ready_o), 32'd1);
            tick();
        end
        chk("bp_w0_valid", 32'(bus.m_valid_o), 32'd1);
        chk("bp_w0_data",  dut_data(),         32'h13121110);
        chk("bp_w0_keep",  32'(bus.m_keep_o),  32'hF);
        chk("bp_w0_last",  32'(bus.m_last_o),  32'd0);
        drive(1, 8'h14, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_s_ready_stall", 32'(bus.s_ready_o), 32'd0);
            tick();
            chk("bp_w0_hold_valid", 32'(bus.m_valid_o), 32'd1);
            chk("bp_w0_hold_data",  dut_data(),         32'h13121110);
            chk("bp_w0_hold_keep",  32'(bus.m_keep_o),  32'hF);
        end
        for (int i = 4; i < 8; i++) begin
            drive(1, 8'(8'h10 + i), (i == 7), 1);
            #1;
            chk("bp_s_ready_drain", 32'(bus.s_ready_o), 32'd1);
            tick();
        end
        chk("bp_w1_valid", 32'(bus.m_valid_o), 32'd1);
        chk("bp_w1_data",  dut_data(),         32'h17161514);
        chk("bp_w1_keep",  32'(bus.m_keep_o),  32'hF);
        chk("bp_w1_last",  32'(bus.m_last_o),  32'd1);
        drive(0, 8'h00, 0, 1);
        tick();
        chk("bp_empty", 32'(bus.m_valid_o), 32'd0);

        // Throughput: 16 beats back to back, one word every fourth beat.
        for (int i = 0; i < 17; i++) begin
            if (i < 16) drive(1, 8'(8'h40 + i), (i == 15), 1);
            else        drive(0, 8'h00, 0, 1);
            #1;
            chk("tp_s_ready", 32'(bus.s_ready_o), 32'd1);
            tick();
            if (i < 16 && (i % 4) == 3) begin
                logic [31:0] w;
                for (int l = 0; l < 4; l++) w[8*l +: 8] = 8'(8'h40 + (i - 3) + l);
                chk("tp_valid", 32'(bus.m_valid_o), 32'd1);
                chk("tp_data",  dut_data(),         w);
                chk("tp_keep",  32'(bus.m_keep_o),  32'hF);
                chk("tp_last",  32'(bus.m_last_o),  32'(i == 15));
            end else begin
                chk("tp_idle", 32'(bus.m_valid_o), 32'd0);
            end
        end

        // Randomized traffic against a packet-level reference model.
        rst_n = 1'b0;
        drive(0, 8'h00, 0, 1);
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        part.delete();
        for (int c = 0; c < 4000; c++) begin
            logic        in_fire, out_fire, stalled, cyc_rst_n;
            logic [31:0] snap_data;
            logic [3:0]  snap_keep;
            logic        snap_last, sv, sl, mr;
            logic [7:0]  sd;
            cyc_rst_n = ($urandom_range(0, 299) != 0);
            sv = ($urandom_range(0, 99) < 70);
            sd = 8'($urandom);
            sl = ($urandom_range(0, 4) == 0);
            mr = ($urandom_range(0, 99) < 65);
            rst_n = cyc_rst_n;
            drive(sv, sd, sl, mr);
            #1;
            chk("rnd_s_ready", 32'(bus.s_ready_o), 32'(!bus.m_valid_o || mr));
            in_fire   = sv && bus.s_ready_o;
            out_fire  = bus.m_valid_o && mr;
            stalled   = bus.m_valid_o && !mr && cyc_rst_n;
            snap_data = dut_data();
            snap_keep = bus.m_keep_o;
            snap_last = bus.m_last_o;
            tick();
            if (!cyc_rst_n) begin
                part.delete();
                exp_q.delete();
            end else begin
                if (out_fire) begin
                    if (exp_q.size() == 0) begin
                        chk("rnd_unexpected_word", 32'd1, 32'd0);
                    end else begin
                        word_t w;
                        w = exp_q.pop_front();
                        chk("rnd_data", snap_data,        w.data);
                        chk("rnd_keep", 32'(snap_keep),   32'(w.keep));
                        chk("rnd_last", 32'(snap_last),   32'(w.last));
                    end
                end
                if (in_fire) begin
                    part.push_back(sd);
                    if (part.size() == R || sl) begin
                        word_t w;
                        w.data = '0;
                        for (int k = 0; k < part.size(); k++) w.data[8*k +: 8] = part[k];
                        w.keep = 4'((1 << part.size()) - 1);
                        w.last = sl;
                        exp_q.push_back(w);
                        part.delete();
                    end
                end
            end
            chk("rnd_m_valid", 32'(bus.m_valid_o), 32'(exp_q.size() != 0));
            if (stalled) begin
                chk("rnd_hold_data", dut_data(),         snap_data);
                chk("rnd_hold_keep", 32'(bus.m_keep_o),  32'(snap_keep));
                chk("rnd_hold_last", 32'(bus.m_last_o),  32'(snap_last));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
